// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst read/write sequencer in front of a latch-based
// 16-bit word RAM (o/D/r/w/addr interface).  Commands arrive over a
// valid/ready handshake; write words stream in and read words stream out
// one per beat, with addresses incrementing from the start address.  Every
// RAM control pin is driven from a register, so r/w/addr/D stay stable for
// whole clock cycles.
// Optional build macro: RAM_CTRL_WRAP_CHECK_EN -- reject bursts that would
// run past the top of the address space (err pulse) instead of wrapping.
module ram_burst_ctrl #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              err,
   output logic              ram_r,
   output logic              ram_w,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_d,
   input  logic [DATA_W-1:0] ram_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_WAIT,
      S_WR_PULSE,
      S_RD_ADDR,
      S_RD_CAP,
      S_RD_HOLD
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              req_ready_q, req_ready_d;
   logic              wdata_ready_q, wdata_ready_d;
   logic              rdata_valid_q, rdata_valid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              done_q, done_d;
   logic              ram_r_q, ram_r_d;
   logic              ram_w_q, ram_w_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_d_q, ram_d_d;
   logic              reject;

`ifdef RAM_CTRL_WRAP_CHECK_EN
   logic              err_q, err_d;
   logic [ADDR_W:0]   span_end;

   // Last beat address computed one bit wider; a carry means the burst would wrap.
   assign span_end = {1'b0, req_addr} + (ADDR_W+1)'(req_len);
   assign reject   = span_end[ADDR_W];
   assign err      = err_q;
`else
   assign reject   = 1'b0;
   assign err      = 1'b0;
`endif

   assign req_ready   = req_ready_q;
   assign wdata_ready = wdata_ready_q;
   assign rdata_valid = rdata_valid_q;
   assign rdata       = rdata_q;
   assign done        = done_q;
   assign ram_r       = ram_r_q;
   assign ram_w       = ram_w_q;
   assign ram_addr    = ram_addr_q;
   assign ram_d       = ram_d_q;

   // Next-state and next-output logic; every output is the registered value of its _d.
   always_comb begin
      state_d       = state_q;
      cur_addr_d    = cur_addr_q;
      cnt_d         = cnt_q;
      req_ready_d   = req_ready_q;
      wdata_ready_d = wdata_ready_q;
      rdata_valid_d = rdata_valid_q;
      rdata_d       = rdata_q;
      done_d        = 1'b0;
      ram_r_d       = ram_r_q;
      ram_w_d       = ram_w_q;
      ram_addr_d    = ram_addr_q;
      ram_d_d       = ram_d_q;
`ifdef RAM_CTRL_WRAP_CHECK_EN
      err_d         = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               if (reject) begin
`ifdef RAM_CTRL_WRAP_CHECK_EN
                  err_d = 1'b1;
`endif
               end else begin
                  cur_addr_d  = req_addr;
                  cnt_d       = req_len;
                  req_ready_d = 1'b0;
                  if (req_wr) begin
                     wdata_ready_d = 1'b1;
                     state_d       = S_WR_WAIT;
                  end else begin
                     state_d       = S_RD_ADDR;
                  end
               end
            end
         end
         S_WR_WAIT: begin
            if (wdata_valid) begin
               ram_d_d       = wdata;
               ram_addr_d    = cur_addr_q;
               ram_w_d       = 1'b1;
               wdata_ready_d = 1'b0;
               state_d       = S_WR_PULSE;
            end
         end
         S_WR_PULSE: begin
            ram_w_d = 1'b0;
            if (cnt_q == '0) begin
               done_d      = 1'b1;
               req_ready_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cur_addr_d    = cur_addr_q + ADDR_W'(1);
               cnt_d         = cnt_q - LEN_W'(1);
               wdata_ready_d = 1'b1;
               state_d       = S_WR_WAIT;
            end
         end
         S_RD_ADDR: begin
            ram_addr_d = cur_addr_q;
            ram_r_d    = 1'b1;
            state_d    = S_RD_CAP;
         end
         S_RD_CAP: begin
            rdata_d       = ram_o;
            rdata_valid_d = 1'b1;
            ram_r_d       = 1'b0;
            state_d       = S_RD_HOLD;
         end
         S_RD_HOLD: begin
            if (rdata_ready) begin
               rdata_valid_d = 1'b0;
               if (cnt_q == '0) begin
                  done_d      = 1'b1;
                  req_ready_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  cur_addr_d = cur_addr_q + ADDR_W'(1);
                  cnt_d      = cnt_q - LEN_W'(1);
                  state_d    = S_RD_ADDR;
               end
            end
         end
         default: begin
            req_ready_d = 1'b1;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any burst and parks in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cur_addr_q    <= '0;
         cnt_q         <= '0;
         req_ready_q   <= 1'b1;
         wdata_ready_q <= 1'b0;
         rdata_valid_q <= 1'b0;
         rdata_q       <= '0;
         done_q        <= 1'b0;
         ram_r_q       <= 1'b0;
         ram_w_q       <= 1'b0;
         ram_addr_q    <= '0;
         ram_d_q       <= '0;
      end else begin
         state_q       <= state_d;
         cur_addr_q    <= cur_addr_d;
         cnt_q         <= cnt_d;
         req_ready_q   <= req_ready_d;
         wdata_ready_q <= wdata_ready_d;
         rdata_valid_q <= rdata_valid_d;
         rdata_q       <= rdata_d;
         done_q        <= done_d;
         ram_r_q       <= ram_r_d;
         ram_w_q       <= ram_w_d;
         ram_addr_q    <= ram_addr_d;
         ram_d_q       <= ram_d_d;
      end
   end

`ifdef RAM_CTRL_WRAP_CHECK_EN
   // Rejected-command error pulse register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end
`endif

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed and random bursts against ram_burst_ctrl with a
// behavioural RAM attached to its pins and a reference memory image.
module tb_ram_burst_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_wr = 1'b0;
   logic [7:0]  req_addr = '0;
   logic [3:0]  req_len = '0;
   logic        wdata_valid = 1'b0, wdata_ready;
   logic [15:0] wdata = '0;
   logic        rdata_valid, rdata_ready = 1'b0;
   logic [15:0] rdata;
   logic        done, err, ram_r, ram_w;
   logic [7:0]  ram_addr;
   logic [15:0] ram_d, ram_o;

   logic [15:0] ram_mem [256];
   logic [15:0] ref_mem [256];
   logic [15:0] wbuf [16];
   int          stall [16];
   int          bp [16];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   ram_burst_ctrl #(.ADDR_W(8), .DATA_W(16), .LEN_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_len(req_len),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
      .done(done), .err(err),
      .ram_r(ram_r), .ram_w(ram_w), .ram_addr(ram_addr), .ram_d(ram_d),
      .ram_o(ram_o)
   );

   // Behavioural RAM: write on the clock edge that ends a w cycle, combinational read.
   always @(posedge clk) if (ram_w === 1'b1) ram_mem[ram_addr] = ram_d;
   assign ram_o = ram_mem[ram_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check("rw_exclusive", 32'(ram_r & ram_w), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_ram_r"}, 32'(ram_r), 32'd0);
      check({tag, "_ram_w"}, 32'(ram_w), 32'd0);
      check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
      check({tag, "_ram_d"}, 32'(ram_d), 32'd0);
      check({tag, "_rdata"}, 32'(rdata), 32'd0);
      check({tag, "_rdata_valid"}, 32'(rdata_valid), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_wdata_ready"}, 32'(wdata_ready), 32'd0);
   endtask

   // Idle cycles with junk write data offered; it must be ignored.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         wdata_valid = 1'b1;
         wdata = 16'($urandom);
         tick();
         check("idle_req_ready", 32'(req_ready), 32'd1);
         check("idle_done", 32'(done), 32'd0);
         check("idle_wdata_ready", 32'(wdata_ready), 32'd0);
         check("idle_ram_w", 32'(ram_w), 32'd0);
      end
      wdata_valid = 1'b0;
   endtask

`ifdef RAM_CTRL_WRAP_CHECK_EN
   function automatic bit overflows(input logic [7:0] a, input logic [3:0] l);
      return (int'(a) + int'(l)) > 255;
   endfunction

   task automatic expect_reject();
      check("rej_err", 32'(err), 32'd1);
      check("rej_req_ready", 32'(req_ready), 32'd1);
      check("rej_ram_w", 32'(ram_w), 32'd0);
      check("rej_ram_r", 32'(ram_r), 32'd0);
      check("rej_done", 32'(done), 32'd0);
      tick();
      check("rej_err_drop", 32'(err), 32'd0);
      check("rej_ram_w2", 32'(ram_w), 32'd0);
      check("rej_done2", 32'(done), 32'd0);
   endtask
`endif

   // Write burst of l+1 words from wbuf, with stall[i] idle cycles before each word.
   task automatic do_write(input logic [7:0] a, input logic [3:0] l);
      logic [7:0] ad;
      req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_len = l;
      tick();
      req_valid = 1'b0; req_addr = 8'($urandom); req_len = 4'($urandom);
`ifdef RAM_CTRL_WRAP_CHECK_EN
      if (overflows(a, l)) begin
         expect_reject();
         return;
      end
`endif
      check("wr_acc_req_ready", 32'(req_ready), 32'd0);
      check("wr_acc_done", 32'(done), 32'd0);
      check("wr_acc_err", 32'(err), 32'd0);
      for (int i = 0; i <= int'(l); i++) begin
         ad = a + 8'(i);
         check("wr_wdata_ready", 32'(wdata_ready), 32'd1);
         for (int s = 0; s < stall[i]; s++) begin
            wdata_valid = 1'b0; wdata = 16'($urandom);
            tick();
            check("wr_stall_wdata_ready", 32'(wdata_ready), 32'd1);
            check("wr_stall_ram_w", 32'(ram_w), 32'd0);
         end
         wdata_valid = 1'b1; wdata = wbuf[i];
         tick();
         wdata_valid = 1'b0; wdata = 16'($urandom);
         check("wr_ram_w", 32'(ram_w), 32'd1);
         check("wr_ram_addr", 32'(ram_addr), 32'(ad));
         check("wr_ram_d", 32'(ram_d), 32'(wbuf[i]));
         check("wr_pulse_wdata_ready", 32'(wdata_ready), 32'd0);
         ref_mem[ad] = wbuf[i];
         tick();
         check("wr_ram_w_drop", 32'(ram_w), 32'd0);
         if (i == int'(l)) begin
            check("wr_done", 32'(done), 32'd1);
            check("wr_end_req_ready", 32'(req_ready), 32'd1);
         end else begin
            check("wr_mid_done", 32'(done), 32'd0);
         end
      end
   endtask

   // Read burst of l+1 words, holding rdata_ready low for bp[i] cycles per word.
   task automatic do_read(input logic [7:0] a, input logic [3:0] l);
      logic [7:0] ad;
      req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_len = l;
      rdata_ready = 1'b0;
      tick();
      req_valid = 1'b0; req_addr = 8'($urandom); req_len = 4'($urandom);
`ifdef RAM_CTRL_WRAP_CHECK_EN
      if (overflows(a, l)) begin
         expect_reject();
         return;
      end
`endif
      check("rd_acc_req_ready", 32'(req_ready), 32'd0);
      check("rd_acc_done", 32'(done), 32'd0);
      check("rd_acc_err", 32'(err), 32'd0);
      for (int i = 0; i <= int'(l); i++) begin
         ad = a + 8'(i);
         check("rd_addr_ram_r", 32'(ram_r), 32'd0);
         tick();
         check("rd_cap_ram_r", 32'(ram_r), 32'd1);
         check("rd_cap_ram_addr", 32'(ram_addr), 32'(ad));
         check("rd_cap_valid", 32'(rdata_valid), 32'd0);
         tick();
         check("rd_valid", 32'(rdata_valid), 32'd1);
         check("rd_data", 32'(rdata), 32'(ref_mem[ad]));
         check("rd_hold_ram_r", 32'(ram_r), 32'd0);
         for (int s = 0; s < bp[i]; s++) begin
            tick();
            check("rd_bp_valid", 32'(rdata_valid), 32'd1);
            check("rd_bp_data", 32'(rdata), 32'(ref_mem[ad]));
            check("rd_bp_ram_r", 32'(ram_r), 32'd0);
            check("rd_bp_addr", 32'(ram_addr), 32'(ad));
         end
         rdata_ready = 1'b1;
         tick();
         rdata_ready = 1'b0;
         check("rd_valid_drop", 32'(rdata_valid), 32'd0);
         if (i == int'(l)) begin
            check("rd_done", 32'(done), 32'd1);
            check("rd_end_req_ready", 32'(req_ready), 32'd1);
         end else begin
            check("rd_mid_done", 32'(done), 32'd0);
         end
      end
   endtask

   initial begin
      int bad;
      logic [15:0] w0;
      logic [7:0]  ra;
      logic [3:0]  rl;

      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 16'($urandom);
         ref_mem[i] = ram_mem[i];
      end
      for (int i = 0; i < 16; i++) begin
         stall[i] = 0;
         bp[i] = 0;
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Reset in the middle of a write burst (2nd WR_PULSE)
      w0 = 16'($urandom);
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h10; req_len = 4'd3;
      tick();
      req_valid = 1'b0;
      wdata_valid = 1'b1; wdata = w0;
      tick();
      wdata_valid = 1'b0;
      tick();
      wdata_valid = 1'b1; wdata = 16'($urandom);
      tick();
      wdata_valid = 1'b0;
      check("rst_mid_ram_w", 32'(ram_w), 32'd1);
      check("rst_mid_ram_addr", 32'(ram_addr), 32'h11);
      ref_mem[8'h10] = w0;
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_req_ready", 32'(req_ready), 32'd1);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_ram_w", 32'(ram_w), 32'd0);
      check("rst_mem_10", 32'(ram_mem[8'h10]), 32'(w0));
      check("rst_mem_11", 32'(ram_mem[8'h11]), 32'(ref_mem[8'h11]));
      check("rst_mem_12", 32'(ram_mem[8'h12]), 32'(ref_mem[8'h12]));
      idle(1);

      // Write 4 words then read them straight back, no gap between bursts
      wbuf[0] = 16'hA5A5; wbuf[1] = 16'h1234; wbuf[2] = 16'hFFFF; wbuf[3] = 16'h0000;
      do_write(8'h20, 4'd3);
      do_read(8'h20, 4'd3);
      check("rb_word0", 32'(ref_mem[8'h20]), 32'hA5A5);
      idle(1);

      // Read backpressure on the first beat
      bp[0] = 5;
      do_read(8'h20, 4'd1);
      bp[0] = 0;
      idle(1);

      // Burst across the top of the address space
      for (int i = 0; i < 3; i++) wbuf[i] = 16'($urandom);
      do_write(8'hFF, 4'd2);
      do_read(8'hFF, 4'd2);
      idle(1);

      // Write data stall
      wbuf[0] = 16'hBEEF; stall[0] = 4;
      do_write(8'h05, 4'd0);
      stall[0] = 0;
      idle(1);

      // Random bursts
      for (int n = 0; n < 14; n++) begin
         ra = 8'($urandom);
         rl = 4'($urandom_range(0, 5));
         if (n % 3 == 0) ra = 8'($urandom_range(250, 255));
         for (int i = 0; i < 16; i++) begin
            wbuf[i]  = 16'($urandom);
            stall[i] = int'($urandom_range(0, 2));
            bp[i]    = int'($urandom_range(0, 2));
         end
         if ($urandom_range(0, 1) == 1) do_write(ra, rl);
         else                           do_read(ra, rl);
         if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(1);

      // Whole memory image against the reference
      bad = 0;
      for (int i = 0; i < 256; i++) if (ram_mem[i] !== ref_mem[i]) bad++;
      check("mem_image_mismatches", 32'(bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
